// File: rtl/dmac_pkg.sv
// Shared constants for the DMAC burst engine: FSM encodings, AXI field values, 4 KB page size.
package dmac_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RREQ  = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WREQ  = 3'd3;
  localparam logic [2:0] ST_WDATA = 3'd4;
  localparam logic [2:0] ST_WRESP = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [12:0] PAGE_BYTES = 13'd4096;

endpackage

// File: rtl/dmac_sync_fifo.sv
// Synchronous beat buffer with full/empty flags; the head word is visible without a pop.
module dmac_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dmac_burst_engine.sv
// Single-channel store-and-forward DMA burst engine on an AXI3-style master port.
// Optional macro DMAC_RESP_ERR_EN adds the sticky err_o response-error flag.
module dmac_burst_engine
  import dmac_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 4,
  parameter int CH_ID      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ID_W-1:0]   arid_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [3:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ID_W-1:0]   awid_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [3:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [ID_W-1:0]   wid_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
`ifdef DMAC_RESP_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int BPB    = DATA_W / 8;
  localparam int SHIFT  = $clog2(BPB);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] src, dst, step;
  logic [LEN_W-1:0]  rem, start_beats;
  logic [BEAT_W-1:0] beats, cnt;
  logic [12:0]       src_room, dst_room;
  logic [31:0]       beat_lim;
  logic              idle_like, last_beat, r_hs, w_hs, fifo_full, fifo_empty;

  // Beats left before each address reaches the next 4 KB page.
  assign src_room = (PAGE_BYTES - {1'b0, src[11:0]}) >> SHIFT;
  assign dst_room = (PAGE_BYTES - {1'b0, dst[11:0]}) >> SHIFT;

  // NOTE: assign a default first in combinational blocks so no path infers a latch.
  always_comb begin
    beat_lim = 32'(MAX_BURST);
    if (32'(rem) < beat_lim)      beat_lim = 32'(rem);
    if (32'(src_room) < beat_lim) beat_lim = 32'(src_room);
    if (32'(dst_room) < beat_lim) beat_lim = 32'(dst_room);
  end

  assign beats       = BEAT_W'(beat_lim);
  assign step        = ADDR_W'(beats) << SHIFT;
  assign start_beats = len_i >> SHIFT;
  assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
  assign last_beat   = (cnt == beats - 1'b1);
  assign r_hs        = rvalid_i && rready_o;
  assign w_hs        = wvalid_o && wready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      src   <= '0;
      dst   <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            src   <= src_i;
            dst   <= dst_i;
            rem   <= start_beats;
            state <= (start_beats == '0) ? ST_DONE : ST_RREQ;
          end
        end
        ST_RREQ: begin
          if (arready_i) begin
            cnt   <= '0;
            state <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          // The beat count ends the read burst; rlast is not trusted.
          if (r_hs) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= ST_WREQ;
          end
        end
        ST_WREQ: begin
          if (awready_i) begin
            cnt   <= '0;
            state <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (w_hs) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (bvalid_i) begin
            src   <= src + step;
            dst   <= dst + step;
            rem   <= rem - LEN_W'(beats);
            state <= (rem == LEN_W'(beats)) ? ST_DONE : ST_RREQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dmac_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_hs),
    .push_data (rdata_i),
    .pop       (w_hs),
    .head      (wdata_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy_o    = !idle_like;
  assign done_o    = (state == ST_DONE);

  assign arid_o    = ID_W'(CH_ID);
  assign araddr_o  = src;
  assign arlen_o   = 4'(beats - 1'b1);
  assign arsize_o  = 3'(SHIFT);
  assign arburst_o = BURST_INCR;
  assign arvalid_o = (state == ST_RREQ);
  assign rready_o  = (state == ST_RDATA) && !fifo_full;

  assign awid_o    = ID_W'(CH_ID);
  assign awaddr_o  = dst;
  assign awlen_o   = 4'(beats - 1'b1);
  assign awsize_o  = 3'(SHIFT);
  assign awburst_o = BURST_INCR;
  assign awvalid_o = (state == ST_WREQ);

  assign wid_o     = ID_W'(CH_ID);
  assign wstrb_o   = '1;
  assign wlast_o   = (state == ST_WDATA) && last_beat;
  assign wvalid_o  = (state == ST_WDATA) && !fifo_empty;
  assign bready_o  = (state == ST_WRESP);

`ifdef DMAC_RESP_ERR_EN
  logic unused_rlast;
  assign unused_rlast = rlast_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (idle_like && start_i) begin
      err_o <= 1'b0;
    end else if ((r_hs && rresp_i != RESP_OKAY) ||
                 (bvalid_i && bready_o && bresp_i != RESP_OKAY)) begin
      err_o <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{rresp_i, bresp_i, rlast_i};
`endif

endmodule

// File: doc/dmac_burst_engine.md
Name: dmac_burst_engine

Overview:
- Parametrised single-channel DMA transfer engine for the next-generation DMAC.
- Moves a byte-length region from a source to a destination address over an AXI3-style master interface, one burst at a time, store-and-forward through an internal FIFO.
- Burst length is configurable, and bursts are split at 4 KB boundaries.
- The APB register file supplies src/dst/len/start and reads busy/done; N instances are arbitrated onto the shared AXI port upstream.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, AXI data width in bits; BPB = DATA_W/8 bytes per beat
- LEN_W, 16, byte-length field width
- MAX_BURST, 16, maximum beats per burst (1..16, AXI3 limit)
- FIFO_DEPTH, 16, beat buffer depth; must be >= MAX_BURST
- ID_W, 4, AXI ID width
- CH_ID, 0, value driven on arid/awid/wid

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle start pulse, accepted only in IDLE/DONE
- src_i  in  ADDR_W  source byte address, BPB-aligned
- dst_i  in  ADDR_W  destination byte address, BPB-aligned
- len_i  in  LEN_W  byte count; low log2(BPB) bits ignored
- busy_o  out  1  transfer in progress
- done_o  out  1  level, set at completion, cleared by next accepted start
- arid_o/araddr_o/arlen_o[3:0]/arsize_o[2:0]/arburst_o[1:0]/arvalid_o  out  AR channel; arready_i in
- rdata_i/rresp_i[1:0]/rlast_i/rvalid_i  in, rready_o out  R channel
- awid_o/awaddr_o/awlen_o/awsize_o/awburst_o/awvalid_o  out  AW channel; awready_i in
- wid_o/wdata_o/wstrb_o/wlast_o/wvalid_o  out  W channel; wready_i in
- bresp_i[1:0]/bvalid_i  in, bready_o out  B channel

Behaviour:
- Reset: all valid/ready outputs 0, busy_o=0, done_o=0, FSM=IDLE, FIFO empty, address/length registers 0.
- Constant outputs: arsize/awsize=log2(BPB); arburst/awburst=INCR; wstrb all ones.
- FSM states: IDLE, RREQ, RDATA, WREQ, WDATA, WRESP, DONE.
- IDLE/DONE + start_i: latch src/dst, set rem_beats=len_i>>log2(BPB), clear done_o.
  - If rem_beats=0: go to DONE next cycle.
  - Otherwise go to RREQ; busy_o=1 from the following cycle.
- Burst size: beats = min(rem_beats, MAX_BURST, (4096 - addr[11:0])/BPB), computed from the source address. The destination burst uses the same beat count; if the destination would cross 4 KB, beats is further reduced to the destination limit, so both bursts are always equal.
- RREQ: arvalid=1, arlen=beats-1; held stable until arready. On handshake go to RDATA.
- RDATA: rready=1 while FIFO not full. Each handshake pushes rdata. The beat with rlast (or beat count reached) goes to WREQ; rlast is not required, the beat count rules.
- WREQ: awvalid=1 with dst and awlen=beats-1; on awready go to WDATA.
- WDATA: wvalid = FIFO not empty; wdata = FIFO head; wlast on the final beat. Pop on handshake; after the last beat go to WRESP.
- WRESP: bready=1. On bvalid: src+=beats*BPB, dst+=beats*BPB, rem_beats-=beats. Go to RREQ if rem_beats>0, else DONE.
- DONE: done_o=1, busy_o=0; stays until start_i.
- Handshake rules:
  - No valid is deasserted or changed before its ready.
  - Valid never depends combinationally on ready.
  - AW is issued only after the full read burst is buffered; at most one outstanding read and one outstanding write.
- start_i while busy: ignored.
- Reset mid-transfer: immediate return to reset state; no response is awaited.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro DMAC_RESP_ERR_EN.
  - With it: adds output err_o (level), set when any rresp_i or bresp_i != OKAY is handshaked. The transfer completes normally and the data is still written. err_o is cleared on the next accepted start; its reset value is 0.
  - Without it: responses are ignored and there is no err_o port.

Decomposition:
- Package dmac_pkg: FSM state enum, AXI burst/size/resp constants (BURST_INCR, RESP_OKAY), 4 KB boundary constant.
- Sub-module dmac_sync_fifo: parametrised DATA_W x FIFO_DEPTH synchronous FIFO with full/empty flags and pointer wrap.

Test Plan:
- len=0x100, src=0x0, dst=0x2000, MAX_BURST=16, DATA_W=32 -> four 16-beat AR/AW bursts, done_o=1, dst words match src.
- len=0x44, MAX_BURST=16 -> bursts of 16 beats then 1 beat (arlen=15, then 0), done_o=1.
- src=0x0FF8, dst=0x3000, len=0x20 -> first burst 2 beats (stops at 0x1000), then 6 beats; no burst crosses 4 KB.
- len=0 -> no AR/AW issued, done_o high 1 cycle after start, busy_o never high.
- Slave with random arready/rvalid/awready/wready/bvalid stalls (0-5 cycles) -> valids held stable, data intact; start_i pulsed while busy is ignored.
- rst asserted during WDATA -> all valids 0 in the same cycle; a subsequent start with len=0x10 completes correctly. With DMAC_RESP_ERR_EN, rresp=SLVERR on one beat -> err_o=1 at done.
